// File: rtl/fft_butterfly_seq_if.sv
// Control and memory-port bundle for fft_butterfly_seq.
// master = butterfly engine side, slave = host/memory side.
interface fft_butterfly_seq_if #(
  parameter int WORDWIDTH = 16
);
  logic                 start_i;
  logic [WORDWIDTH-1:0] base_addr_i;
  logic [WORDWIDTH-1:0] num_pairs_i;
  logic                 mem_en_o;
  logic                 mem_we_o;
  logic [WORDWIDTH-1:0] mem_addr_o;
  logic [WORDWIDTH-1:0] mem_wdata_o;
  logic [WORDWIDTH-1:0] mem_rdata_a_i;
  logic [WORDWIDTH-1:0] mem_rdata_b_i;
  logic                 busy_o;
  logic                 done_o;
  logic                 err_o;

  modport master (
    input  start_i, base_addr_i, num_pairs_i, mem_rdata_a_i, mem_rdata_b_i,
    output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o, done_o, err_o
  );

  modport slave (
    output start_i, base_addr_i, num_pairs_i, mem_rdata_a_i, mem_rdata_b_i,
    input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/fft_butterfly_seq.sv
// In-place radix-2 butterfly pass over num_pairs adjacent (a,b) words: [A]=a+b, [A+1]=a-b.
// Define FFT_BUTTERFLY_SAT_EN to saturate the results instead of wrapping.
module fft_butterfly_seq #(
  parameter int MEMWIDTH  = 65,
  parameter int WORDWIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  fft_butterfly_seq_if.master   bus
);
  localparam int W = WORDWIDTH;
  localparam logic [W-1:0]   ONE       = 1;
  localparam logic [W-1:0]   TWO       = 2;
  localparam logic [W+1:0]   MEM_WORDS = (W+2)'(MEMWIDTH);

  typedef enum logic [2:0] {IDLE, RD, WAIT, WR_SUM, WR_DIFF, DONE} state_t;

  state_t       state_q, state_d;
  logic [W-1:0] num_q, num_d;
  logic [W-1:0] k_q, k_d;
  logic [W-1:0] pa_q, pa_d;
  logic [W-1:0] a_q, a_d, b_q, b_d;
  logic         en_q, en_d, we_q, we_d;
  logic [W-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic         busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic [W+1:0] end_addr;
  logic [W-1:0] k_nxt;
  logic [W-1:0] sum_w, diff_w;

  // One past the last touched word; wide enough that the range check cannot overflow.
  assign end_addr = {2'b00, bus.base_addr_i} + {1'b0, bus.num_pairs_i, 1'b0};
  assign k_nxt    = k_q + ONE;

`ifdef FFT_BUTTERFLY_SAT_EN
  localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};
  logic [W:0] sum_x, diff_x;
  always_comb begin
    sum_x  = {a_d[W-1], a_d} + {b_d[W-1], b_d};
    diff_x = {a_d[W-1], a_d} - {b_d[W-1], b_d};
    sum_w  = (sum_x[W] != sum_x[W-1])   ? (sum_x[W]  ? SMIN : SMAX) : sum_x[W-1:0];
    diff_w = (diff_x[W] != diff_x[W-1]) ? (diff_x[W] ? SMIN : SMAX) : diff_x[W-1:0];
  end
`else
  always_comb begin
    sum_w  = a_d + b_d;
    diff_w = a_d - b_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    k_d     = k_q;
    pa_d    = pa_q;
    a_d     = a_q;
    b_d     = b_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: if (bus.start_i) begin
        if (end_addr > MEM_WORDS) begin
          err_d = 1'b1;
        end else begin
          num_d   = bus.num_pairs_i;
          k_d     = '0;
          pa_d    = bus.base_addr_i;
          state_d = (bus.num_pairs_i == '0) ? DONE : RD;
        end
      end
      RD:     state_d = WAIT;
      WAIT: begin
        a_d     = bus.mem_rdata_a_i;
        b_d     = bus.mem_rdata_b_i;
        state_d = WR_SUM;
      end
      WR_SUM: state_d = WR_DIFF;
      WR_DIFF: begin
        k_d     = k_nxt;
        pa_d    = pa_q + TWO;
        state_d = (k_nxt < num_q) ? RD : DONE;
      end
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so the registered copies line up with state_q.
    en_d    = 1'b0;
    we_d    = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    done_d  = 1'b0;
    busy_d  = (state_d != IDLE);
    unique case (state_d)
      RD, WAIT: begin
        en_d   = 1'b1;
        addr_d = pa_d;
      end
      WR_SUM: begin
        we_d    = 1'b1;
        addr_d  = pa_d;
        wdata_d = sum_w;
      end
      WR_DIFF: begin
        we_d    = 1'b1;
        addr_d  = pa_d + ONE;
        wdata_d = diff_w;
      end
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      num_q   <= '0;
      k_q     <= '0;
      pa_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      k_q     <= k_d;
      pa_q    <= pa_d;
      a_q     <= a_d;
      b_q     <= b_d;
      en_q    <= en_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.mem_en_o    = en_q;
  assign bus.mem_we_o    = we_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;
  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.err_o       = err_q;
endmodule

// File: tb/tb_fft_butterfly_seq.sv
// Directed bench for fft_butterfly_seq with a behavioural 65-word dual-read memory.
module tb_fft_butterfly_seq;
  localparam int MEMW = 65;

`ifdef FFT_BUTTERFLY_SAT_EN
  localparam logic [15:0] EXP_OVF_SUM  = 16'h7FFF;
  localparam logic [15:0] EXP_UNF_DIFF = 16'h8000;
`else
  localparam logic [15:0] EXP_OVF_SUM  = 16'h8000;
  localparam logic [15:0] EXP_UNF_DIFF = 16'h7FFF;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft_butterfly_seq_if #(.WORDWIDTH(16)) bus();

  fft_butterfly_seq #(.MEMWIDTH(MEMW), .WORDWIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] mem [0:MEMW-1];
  int acc_cnt = 0;
  int both_cnt = 0;
  int checks = 0;
  int errors = 0;

  // Memory: registered reads of A and A+1, writes on the clock edge.
  always @(posedge clk) begin
    if (bus.mem_en_o) begin
      if (int'(bus.mem_addr_o) < MEMW)     bus.mem_rdata_a_i <= mem[bus.mem_addr_o];
      if (int'(bus.mem_addr_o) + 1 < MEMW) bus.mem_rdata_b_i <= mem[bus.mem_addr_o + 16'd1];
    end
    if (bus.mem_we_o && int'(bus.mem_addr_o) < MEMW) mem[bus.mem_addr_o] = bus.mem_wdata_o;
    if (bus.mem_en_o || bus.mem_we_o) acc_cnt = acc_cnt + 1;
    if (bus.mem_en_o && bus.mem_we_o) both_cnt = both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".en"},    32'(bus.mem_en_o),    32'd0);
    check({tag, ".we"},    32'(bus.mem_we_o),    32'd0);
    check({tag, ".addr"},  32'(bus.mem_addr_o),  32'd0);
    check({tag, ".wdata"}, 32'(bus.mem_wdata_o), 32'd0);
    check({tag, ".busy"},  32'(bus.busy_o),      32'd0);
    check({tag, ".done"},  32'(bus.done_o),      32'd0);
    check({tag, ".err"},   32'(bus.err_o),       32'd0);
  endtask

  // Issues a start and watches `limit` cycles; cycle 1 is the one right after the accepting edge.
  task automatic run_pass(input logic [15:0] base, input logic [15:0] n, input bit restart,
                          input int limit, output int done_cyc, output int ndone);
    done_cyc = -1;
    ndone    = 0;
    acc_cnt  = 0;
    both_cnt = 0;
    @(negedge clk);
    bus.start_i     = 1'b1;
    bus.base_addr_i = base;
    bus.num_pairs_i = n;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      bus.start_i = restart && (c == 2 || c == 5);
      if (bus.done_o) begin
        ndone++;
        if (done_cyc < 0) done_cyc = c;
      end
    end
    bus.start_i = 1'b0;
  endtask

  int dc, nd;

  initial begin
    for (int i = 0; i < MEMW; i++) mem[i] = '0;
    bus.start_i = 0; bus.base_addr_i = 0; bus.num_pairs_i = 0;
    bus.mem_rdata_a_i = 0; bus.mem_rdata_b_i = 0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b1;

    // Basic pair: [0]=5,[1]=3 -> 8,2, done in cycle 5
    mem[0] = 16'd5; mem[1] = 16'd3;
    run_pass(16'd0, 16'd1, 1'b0, 12, dc, nd);
    check("basic.done_cyc", 32'(dc), 32'd5);
    check("basic.ndone",    32'(nd), 32'd1);
    check("basic.mem0",     32'(mem[0]), 32'd8);
    check("basic.mem1",     32'(mem[1]), 32'd2);
    check("basic.acc",      32'(acc_cnt), 32'd4);
    check("basic.both",     32'(both_cnt), 32'd0);
    check_idle_outputs("basic.after");

    // Zero pairs: no access, done next cycle
    run_pass(16'd5, 16'd0, 1'b0, 6, dc, nd);
    check("n0.done_cyc", 32'(dc), 32'd1);
    check("n0.ndone",    32'(nd), 32'd1);
    check("n0.acc",      32'(acc_cnt), 32'd0);

    // Out of range: base 60 + 6 words > 65
    acc_cnt = 0;
    @(negedge clk);
    bus.start_i = 1'b1; bus.base_addr_i = 16'd60; bus.num_pairs_i = 16'd3;
    @(negedge clk);
    bus.start_i = 1'b0;
    check("range.err",  32'(bus.err_o),  32'd1);
    check("range.busy", 32'(bus.busy_o), 32'd0);
    check("range.en",   32'(bus.mem_en_o), 32'd0);
    @(negedge clk);
    check_idle_outputs("range.next");
    repeat (3) @(negedge clk);
    check("range.acc", 32'(acc_cnt), 32'd0);

    // Exactly at the top: base 63, one pair uses 63..64
    mem[63] = 16'd1; mem[64] = 16'd2;
    run_pass(16'd63, 16'd1, 1'b0, 8, dc, nd);
    check("edge.done_cyc", 32'(dc), 32'd5);
    check("edge.mem63", 32'(mem[63]), 32'd3);
    check("edge.mem64", 32'(mem[64]), 32'hFFFF);

    // Signed overflow in sum and difference
    mem[10] = 16'h7FFF; mem[11] = 16'h0001;
    mem[12] = 16'h8000; mem[13] = 16'h0001;
    run_pass(16'd10, 16'd2, 1'b0, 14, dc, nd);
    check("ovf.done_cyc", 32'(dc), 32'd9);
    check("ovf.sum0",  32'(mem[10]), 32'(EXP_OVF_SUM));
    check("ovf.diff0", 32'(mem[11]), 32'h7FFE);
    check("ovf.sum1",  32'(mem[12]), 32'h8001);
    check("ovf.diff1", 32'(mem[13]), 32'(EXP_UNF_DIFF));

    // Negative difference
    mem[20] = 16'd3; mem[21] = 16'd7;
    run_pass(16'd20, 16'd1, 1'b0, 8, dc, nd);
    check("neg.sum",  32'(mem[20]), 32'd10);
    check("neg.diff", 32'(mem[21]), 32'hFFFC);

    // Start pulses while busy are ignored
    mem[40] = 16'd1; mem[41] = 16'd1; mem[42] = 16'd9; mem[43] = 16'd4;
    run_pass(16'd40, 16'd2, 1'b1, 20, dc, nd);
    check("busy.done_cyc", 32'(dc), 32'd9);
    check("busy.ndone", 32'(nd), 32'd1);
    check("busy.acc",   32'(acc_cnt), 32'd8);
    check("busy.mem40", 32'(mem[40]), 32'd2);
    check("busy.mem41", 32'(mem[41]), 32'd0);
    check("busy.mem42", 32'(mem[42]), 32'd13);
    check("busy.mem43", 32'(mem[43]), 32'd5);

    // Reset on the WR_SUM cycle of pair 2 (cycle 11) aborts the pass for good
    mem[30] = 16'd10; mem[31] = 16'd4; mem[32] = 16'd20; mem[33] = 16'd5;
    mem[34] = 16'd7;  mem[35] = 16'd2; mem[36] = 16'd9;  mem[37] = 16'd1;
    acc_cnt = 0;
    @(negedge clk);
    bus.start_i = 1'b1; bus.base_addr_i = 16'd30; bus.num_pairs_i = 16'd4;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (10) @(negedge clk);
    check("rstmid.we",   32'(bus.mem_we_o),   32'd1);
    check("rstmid.addr", 32'(bus.mem_addr_o), 32'd34);
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("rstmid.after");
    @(negedge clk);
    rst = 1'b1;
    acc_cnt = 0;
    repeat (20) @(negedge clk);
    check("rstmid.noresume.acc",  32'(acc_cnt), 32'd0);
    check("rstmid.noresume.busy", 32'(bus.busy_o), 32'd0);
    check("rstmid.mem30", 32'(mem[30]), 32'd14);
    check("rstmid.mem31", 32'(mem[31]), 32'd6);
    check("rstmid.mem32", 32'(mem[32]), 32'd25);
    check("rstmid.mem33", 32'(mem[33]), 32'd15);
    check("rstmid.mem35", 32'(mem[35]), 32'd2);
    check("rstmid.mem36", 32'(mem[36]), 32'd9);
    check("rstmid.mem37", 32'(mem[37]), 32'd1);

    // A fresh pass after the abort still works
    mem[50] = 16'd6; mem[51] = 16'd2;
    run_pass(16'd50, 16'd1, 1'b0, 8, dc, nd);
    check("post.done_cyc", 32'(dc), 32'd5);
    check("post.mem50", 32'(mem[50]), 32'd8);
    check("post.mem51", 32'(mem[51]), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
